// File: rtl/ppl_pkg.sv
// ppl_pkg: shared state enum, ROB entry layout and default
// frame/width constants for the ppl pipeline family.
package ppl_pkg;

  localparam int PPL_H_DISP = 1280;
  localparam int PPL_V_DISP = 720;
  localparam int PPL_ADDR_W = 20;
  localparam int PPL_BLK_W  = 15;
  localparam int PPL_TEX_W  = 13;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    VSYNC
  } ppl_state_e;

  typedef struct packed {
    logic [PPL_ADDR_W-1:0] pix;
    logic [PPL_BLK_W-1:0]  blk;
    logic [PPL_TEX_W-1:0]  tex;
  } rob_entry_t;

endpackage

// File: rtl/ppl_rr_arb.sv
// ppl_rr_arb: N-wide round-robin arbiter, grants the first
// requester at or after ptr (one-hot, zero when no request).
module ppl_rr_arb #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // scan requesters starting at ptr, take the first one
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppl_lane_sched.sv
// ppl_lane_sched: raster-order issue to LANES ray lanes, ROB
// reorder, in-order retire, vs per frame. PPL_PERF_EN adds perf ports.
module ppl_lane_sched
  import ppl_pkg::*;
#(
  parameter int H_DISP    = PPL_H_DISP,
  parameter int V_DISP    = PPL_V_DISP,
  parameter int LANES     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ADDR_W    = PPL_ADDR_W,
  parameter int BLK_W     = PPL_BLK_W,
  parameter int TEX_W     = PPL_TEX_W,
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                   clk_ppl,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [LANES-1:0]       lane_ready,
  output logic [LANES-1:0]       issue_valid,
  output logic [ADDR_W-1:0]      issue_pixel_addr,
  output logic [TAG_W-1:0]       issue_tag,
  input  logic [LANES-1:0]       done_valid,
  input  logic [LANES*TAG_W-1:0] done_tag,
  input  logic [LANES*BLK_W-1:0] done_block_addr,
  input  logic [LANES*TEX_W-1:0] done_texture_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      pixel_addr_out,
  output logic [BLK_W-1:0]       block_addr,
  output logic [TEX_W-1:0]       texture_addr,
  output logic                   vs,
  output logic                   busy,
  output logic                   err_tag
`ifdef PPL_PERF_EN
  ,
  output logic [31:0]            perf_frame_cycles,
  output logic [31:0]            perf_stall_cycles
`endif
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX =
    ADDR_W'(H_DISP * V_DISP - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pix;
    logic [BLK_W-1:0]  blk;
    logic [TEX_W-1:0]  tex;
  } ent_t;

  ppl_state_e r_state;
  ppl_state_e w_state_nxt;

  logic [TAG_W:0]       r_head;
  logic [TAG_W:0]       r_tail;
  logic [TAG_W-1:0]     w_hidx;
  logic [TAG_W-1:0]     w_tidx;
  logic [ROB_DEPTH-1:0] r_outst;
  logic [ROB_DEPTH-1:0] r_valid;
  ent_t                 r_ent [ROB_DEPTH];

  logic [ADDR_W-1:0] r_pix;
  logic [PW-1:0]     r_rr;
  logic [PW-1:0]     w_rr_nxt;
  logic [PW-1:0]     w_gidx;
  logic [LANES-1:0]  w_grant;
  logic [TAG_W-1:0]  w_dtag [LANES];

  logic w_full;
  logic w_empty;
  logic w_retire;
  logic w_can_issue;
  logic w_xfer;
  logic w_last;

  logic r_out_valid;
  ent_t r_out;
  logic r_err;

  assign w_hidx  = r_head[TAG_W-1:0];
  assign w_tidx  = r_tail[TAG_W-1:0];
  assign w_full  = (r_head[TAG_W] != r_tail[TAG_W])
                && (w_hidx == w_tidx);
  assign w_empty = (r_head == r_tail);

  // a full ROB still issues when its head leaves this cycle
  assign w_retire    = r_valid[w_hidx]
                    && (!r_out_valid || out_ready);
  assign w_can_issue = (r_state == RUN)
                    && (!w_full || w_retire);

  ppl_rr_arb #(
    .N (LANES)
  ) u_arb (
    .req   (lane_ready),
    .ptr   (r_rr),
    .grant (w_grant)
  );

  assign issue_valid = w_can_issue ? w_grant : '0;
  assign w_xfer      = |(issue_valid & lane_ready);
  assign w_last      = (r_pix == LAST_PIX);

  // granted lane index and the round-robin pointer after it
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_grant[i]) w_gidx = PW'(i);
    end
    if (int'(w_gidx) == LANES - 1) w_rr_nxt = '0;
    else w_rr_nxt = w_gidx + 1'b1;
  end

  // unpack per-lane completion tags
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_dtag[i] = done_tag[i*TAG_W +: TAG_W];
    end
  end

  // frame state register
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // frame sequencing: run, drain outstanding rays, vsync pulse
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (frame_start) w_state_nxt = RUN;
      RUN:     if (w_xfer && w_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_empty && !r_out_valid) w_state_nxt = VSYNC;
      VSYNC:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // raster pixel counter and round-robin pointer
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
      r_rr  <= '0;
    end else begin
      if (r_state == IDLE && frame_start) begin
        r_pix <= '0;
      end else if (w_xfer) begin
        r_pix <= r_pix + 1'b1;
        r_rr  <= w_rr_nxt;
      end
    end
  end

  // reorder buffer: allocate on issue, fill on completion, free on retire
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_outst <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      for (int k = 0; k < ROB_DEPTH; k++) r_ent[k] <= '0;
    end else begin
      if (w_retire) begin
        r_valid[w_hidx] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_xfer) begin
        r_outst[w_tidx]   <= 1'b1;
        r_ent[w_tidx].pix <= r_pix;
        r_tail            <= r_tail + 1'b1;
      end
      for (int i = 0; i < LANES; i++) begin
        if (done_valid[i]) begin
          if (r_outst[w_dtag[i]]) begin
            r_outst[w_dtag[i]]   <= 1'b0;
            r_valid[w_dtag[i]]   <= 1'b1;
            r_ent[w_dtag[i]].blk <=
              done_block_addr[i*BLK_W +: BLK_W];
            r_ent[w_dtag[i]].tex <=
              done_texture_addr[i*TEX_W +: TEX_W];
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  // retire register: hold until the writer takes it
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_retire) begin
      r_out_valid <= 1'b1;
      r_out       <= r_ent[w_hidx];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign issue_pixel_addr = r_pix;
  assign issue_tag        = w_tidx;
  assign out_valid        = r_out_valid;
  assign pixel_addr_out   = r_out.pix;
  assign block_addr       = r_out.blk;
  assign texture_addr     = r_out.tex;
  assign vs               = (r_state == VSYNC);
  assign busy             = (r_state != IDLE);
  assign err_tag          = r_err;

`ifdef PPL_PERF_EN
  logic [31:0] r_frm_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_perf_frm;
  logic [31:0] r_perf_stall;

  // frame/stall cycle counters, published at vsync
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      r_frm_cnt    <= '0;
      r_stall_cnt  <= '0;
      r_perf_frm   <= '0;
      r_perf_stall <= '0;
    end else if (r_state == IDLE && frame_start) begin
      r_frm_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == RUN || r_state == DRAIN) begin
      r_frm_cnt <= r_frm_cnt + 1'b1;
      if (r_state == RUN && (w_full || !(|lane_ready)))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end else if (r_state == VSYNC) begin
      r_perf_frm   <= r_frm_cnt;
      r_perf_stall <= r_stall_cnt;
      r_frm_cnt    <= '0;
      r_stall_cnt  <= '0;
    end
  end

  assign perf_frame_cycles = r_perf_frm;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_ppl_lane_sched.sv
// tb_ppl_lane_sched: 4x2 frame, 2 lanes, 4-slot ROB; lane models
// reply in order, reversed, or never; scoreboard checks raster retire.
module tb_ppl_lane_sched;

  localparam int NPIX = 8;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [1:0]  lane_ready;
  logic [1:0]  issue_valid;
  logic [7:0]  issue_pixel_addr;
  logic [1:0]  issue_tag;
  logic [1:0]  done_valid;
  logic [3:0]  done_tag;
  logic [29:0] done_block_addr;
  logic [25:0] done_texture_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  pixel_addr_out;
  logic [14:0] block_addr;
  logic [12:0] texture_addr;
  logic        vs;
  logic        busy;
  logic        err_tag;

  ppl_lane_sched #(
    .H_DISP    (4),
    .V_DISP    (2),
    .LANES     (2),
    .ROB_DEPTH (4),
    .ADDR_W    (8),
    .BLK_W     (15),
    .TEX_W     (13)
  ) dut (
    .clk_ppl           (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .lane_ready        (lane_ready),
    .issue_valid       (issue_valid),
    .issue_pixel_addr  (issue_pixel_addr),
    .issue_tag         (issue_tag),
    .done_valid        (done_valid),
    .done_tag          (done_tag),
    .done_block_addr   (done_block_addr),
    .done_texture_addr (done_texture_addr),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .pixel_addr_out    (pixel_addr_out),
    .block_addr        (block_addr),
    .texture_addr      (texture_addr),
    .vs                (vs),
    .busy              (busy),
    .err_tag           (err_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lane;
    int tag;
    int pix;
    int due;
  } pend_t;

  pend_t pq[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int mode   = 0;
  int m_issued, m_retired, m_tail, m_rr, m_win;
  int vs_cnt, hold_n, late_issue, ov_seen;
  int first_done, first_out;
  int inj_tag = -1;
  bit fs_req, hold_or, rdy_pat;
  bit p_ov, p_or, p_vs;
  logic [7:0]  p_pix;
  logic [14:0] p_blk;
  logic [12:0] p_tex;

  function automatic logic [14:0] blk_of(int pix);
    return 15'(pix * 37 + 5);
  endfunction

  function automatic logic [12:0] tex_of(int pix);
    return 13'(pix ^ 'ha5);
  endfunction

  function automatic logic [1:0] exp_grant(logic [1:0] rdy, int rr);
    logic [1:0] g;
    g = '0;
    for (int k = 0; k < 2; k++) begin
      if (g == 0 && rdy[(rr + k) % 2]) g[(rr + k) % 2] = 1'b1;
    end
    return g;
  endfunction

  task automatic chk(bit ok, string name, int act, int exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic drive_done(pend_t e);
    done_valid[e.lane]                = 1'b1;
    done_tag[e.lane*2 +: 2]           = 2'(e.tag);
    done_block_addr[e.lane*15 +: 15]  = blk_of(e.pix);
    done_texture_addr[e.lane*13 +: 13] = tex_of(e.pix);
    if (e.pix == 0) first_done = cyc;
  endtask

  task automatic clear_model();
    pq.delete();
    m_issued  = 0;
    m_retired = 0;
    m_win     = 0;
    p_ov = 0;
    p_or = 0;
    p_vs = 0;
  endtask

  // one clock: drive inputs after negedge, sample at negedge+1
  task automatic step();
    pend_t e;
    int best;
    logic [1:0] g;
    int ln;
    @(negedge clk);
    cyc++;
    done_valid        = '0;
    done_tag          = '0;
    done_block_addr   = '0;
    done_texture_addr = '0;
    frame_start = fs_req;
    fs_req      = 0;
    out_ready   = !hold_or;
    if (rdy_pat)
      lane_ready = (cyc % 5 == 0) ? 2'b00 :
                   ((cyc % 3 == 0) ? 2'b10 : 2'b11);
    else
      lane_ready = 2'b11;
    if (mode == 0) begin
      for (int l = 0; l < 2; l++) begin
        for (int j = 0; j < pq.size(); j++) begin
          if (pq[j].lane == l && pq[j].due <= cyc) begin
            drive_done(pq[j]);
            pq.delete(j);
            break;
          end
        end
      end
    end else if (mode == 1) begin
      if (m_issued >= 4 * (m_win + 1)) begin
        best = -1;
        for (int j = 0; j < pq.size(); j++) begin
          if (pq[j].pix / 4 == m_win) begin
            if (best < 0 || pq[j].pix > pq[best].pix) best = j;
          end
        end
        if (best >= 0) begin
          drive_done(pq[best]);
          pq.delete(best);
        end else begin
          m_win++;
        end
      end
    end
    if (inj_tag >= 0) begin
      done_valid[0] = 1'b1;
      done_tag[1:0] = 2'(inj_tag);
      done_block_addr[14:0] = 15'h7fff;
      inj_tag = -1;
    end
    #1;
    if (!rst) begin
      if (issue_valid != 0) begin
        g = exp_grant(lane_ready, m_rr);
        chk(issue_valid == g, "issue_grant",
            int'(issue_valid), int'(g));
        if (mode == 2 && m_issued >= 4) late_issue++;
        if ((issue_valid & lane_ready) != 0) begin
          ln = issue_valid[1] ? 1 : 0;
          chk(int'(issue_pixel_addr) == m_issued, "issue_pix",
              int'(issue_pixel_addr), m_issued);
          chk(int'(issue_tag) == m_tail % 4, "issue_tag",
              int'(issue_tag), m_tail % 4);
          chk(m_issued < NPIX, "issue_extra", m_issued, NPIX - 1);
          e.lane = ln;
          e.tag  = int'(issue_tag);
          e.pix  = int'(issue_pixel_addr);
          e.due  = cyc + 3;
          pq.push_back(e);
          m_issued++;
          m_tail++;
          m_rr = (ln + 1) % 2;
        end
      end
      if (p_ov && !p_or) begin
        hold_n++;
        chk(out_valid && pixel_addr_out == p_pix &&
            block_addr == p_blk && texture_addr == p_tex,
            "hold_stable", int'(pixel_addr_out), int'(p_pix));
      end
      if (out_valid) ov_seen++;
      if (out_valid && out_ready) begin
        chk(int'(pixel_addr_out) == m_retired, "out_pix",
            int'(pixel_addr_out), m_retired);
        chk(block_addr == blk_of(m_retired), "out_blk",
            int'(block_addr), int'(blk_of(m_retired)));
        chk(texture_addr == tex_of(m_retired), "out_tex",
            int'(texture_addr), int'(tex_of(m_retired)));
        if (m_retired == 0) first_out = cyc;
        m_retired++;
      end
      if (vs) begin
        vs_cnt++;
        chk(m_retired == NPIX && !p_vs && !out_valid, "vs_at_end",
            m_retired, NPIX);
      end
      p_ov  = out_valid;
      p_or  = out_ready;
      p_vs  = vs;
      p_pix = pixel_addr_out;
      p_blk = block_addr;
      p_tex = texture_addr;
    end
  endtask

  task automatic run_frame(string name);
    int v0;
    bit got;
    clear_model();
    v0  = vs_cnt;
    got = 0;
    fs_req = 1;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (vs_cnt != v0) got = 1;
    end
    chk(got, {name, "_vs_timeout"}, int'(got), 1);
    step();
    chk(m_retired == NPIX, {name, "_count"}, m_retired, NPIX);
    chk(vs_cnt == v0 + 1, {name, "_vs_once"}, vs_cnt - v0, 1);
    chk(!busy, {name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    bit got;
    int v0;
    rst = 1'b1;
    frame_start = 1'b0;
    lane_ready  = 2'b00;
    out_ready   = 1'b1;
    done_valid  = '0;
    done_tag    = '0;
    done_block_addr   = '0;
    done_texture_addr = '0;
    m_tail = 0;
    m_rr   = 0;
    vs_cnt = 0;
    clear_model();
    repeat (3) step();
    chk(issue_valid == 0, "rst_issue_valid", int'(issue_valid), 0);
    chk(!out_valid, "rst_out_valid", int'(out_valid), 0);
    chk(!vs && !busy, "rst_vs_busy", int'({vs, busy}), 0);
    chk(!err_tag, "rst_err_tag", int'(err_tag), 0);
    chk(issue_tag == 0 && issue_pixel_addr == 0, "rst_issue_regs",
        int'(issue_pixel_addr), 0);
    chk(pixel_addr_out == 0 && block_addr == 0, "rst_out_regs",
        int'(block_addr), 0);
    rst = 1'b0;
    step();

    // in-order replies, latency 3, irregular lane readiness
    mode = 0;
    rdy_pat = 1;
    run_frame("inorder");
    chk(first_out - first_done == 2, "min_latency",
        first_out - first_done, 2);
    chk(m_tail == 8, "tail_after_frame", m_tail, 8);
    rdy_pat = 0;

    // reversed replies within each 4-slot window
    mode = 1;
    run_frame("reverse");

    // completion to an idle slot while idle
    mode = 0;
    chk(!err_tag, "err_pre", int'(err_tag), 0);
    inj_tag = 2;
    repeat (2) step();
    chk(err_tag, "err_set", int'(err_tag), 1);
    chk(!out_valid && !busy, "err_no_output",
        int'({out_valid, busy}), 0);

    // writer back-pressure for 10 cycles mid-frame
    clear_model();
    hold_n = 0;
    v0  = vs_cnt;
    got = 0;
    fs_req = 1;
    for (int i = 0; i < 200 && m_retired < 3; i++) step();
    hold_or = 1;
    repeat (10) step();
    hold_or = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (vs_cnt != v0) got = 1;
    end
    chk(got, "hold_vs_timeout", int'(got), 1);
    chk(m_retired == NPIX, "hold_count", m_retired, NPIX);
    chk(hold_n >= 5, "hold_exercised", hold_n, 5);
    chk(err_tag, "err_sticky", int'(err_tag), 1);

    // reset while draining aborts the frame
    clear_model();
    v0 = vs_cnt;
    fs_req = 1;
    for (int i = 0; i < 200 && m_issued < NPIX; i++) step();
    step();
    chk(busy && m_issued == NPIX, "drain_reached",
        m_issued, NPIX);
    #2;
    rst = 1'b1;
    clear_model();
    m_tail = 0;
    m_rr   = 0;
    step();
    chk(issue_valid == 0 && !out_valid && !vs && !busy,
        "rst_drain_outputs", int'({issue_valid, out_valid, vs, busy}), 0);
    chk(!err_tag, "rst_drain_err", int'(err_tag), 0);
    chk(pixel_addr_out == 0 && issue_tag == 0, "rst_drain_regs",
        int'(pixel_addr_out), 0);
    chk(vs_cnt == v0, "rst_no_vs", vs_cnt - v0, 0);
    rst = 1'b0;
    step();
    mode = 0;
    run_frame("restart");

    // lanes never reply: ROB fills after 4 issues
    mode = 2;
    clear_model();
    late_issue = 0;
    ov_seen    = 0;
    fs_req = 1;
    repeat (40) step();
    chk(m_issued == 4, "full_issued", m_issued, 4);
    chk(late_issue == 0, "full_no_issue", late_issue, 0);
    chk(busy, "full_busy", int'(busy), 1);
    chk(ov_seen == 0, "full_no_out", ov_seen, 0);
    #2;
    rst = 1'b1;
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
